// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, stall encoding, load codes
// and the packed layout of the EX->MEM bus.
package mem_stage_pkg;
   localparam int EX_TO_MEM_WD = 146;
   localparam int MEM_TO_WB_WD = 136;
   localparam int MEM_TO_ID_WD = 104;
   localparam int STALL_BUS    = 6;

   localparam int STALL_MEM = 3;
   localparam int STALL_WB  = 4;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [3:0] LD_LW  = 4'b1111;
   localparam logic [3:0] LD_LB  = 4'b0001;
   localparam logic [3:0] LD_LBU = 4'b0010;
   localparam logic [3:0] LD_LH  = 4'b0011;
   localparam logic [3:0] LD_LHU = 4'b0100;

   typedef struct packed {
      logic [3:0]  data_ram_readen;
      logic        hi_we;
      logic        lo_we;
      logic [31:0] hi_ex;
      logic [31:0] lo_ex;
      logic [31:0] ex_pc;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_to_mem_t;
endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts the addressed byte/half/word from an SRAM read word and
// sign- or zero-extends it according to the load code.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [3:0]  code,
   input  logic [1:0]  addr,
   input  logic [31:0] word,
   output logic [31:0] data
);
   logic [7:0]  lanes [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lanes[gi] = word[gi*8 +: 8];
      end
   endgenerate

   assign byte_sel = lanes[addr];
   assign half_sel = addr[1] ? word[31:16] : word[15:0];

   always_comb begin
      data = '0;
      case (code)
         LD_LW:   data = word;
         LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  data = {24'b0, byte_sel};
         LD_LH:   data = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  data = {16'b0, half_sel};
         default: data = '0;
      endcase
   end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one input register bank, a read-data hold register that
// preserves the SRAM word across stalls, and load alignment into rf_wdata.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_BUS-1:0]    stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);
   ex_to_mem_t  stage_reg;
   logic [31:0] hold_data_reg;
   logic        hold_valid_reg;
   logic        load_en;
   logic        bubble_en;
   logic [31:0] rdata_eff;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;

   assign load_en   = (stall[STALL_MEM] == NO_STOP);
   assign bubble_en = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == NO_STOP);

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_reg      <= '0;
         hold_data_reg  <= '0;
         hold_valid_reg <= 1'b0;
      end else if (bubble_en) begin
         stage_reg      <= '0;
         hold_valid_reg <= 1'b0;
      end else if (load_en) begin
         stage_reg      <= ex_to_mem_bus;
         hold_valid_reg <= 1'b0;
      end else if (!hold_valid_reg) begin
         // SRAM word is only valid in the first resident cycle; keep it for the rest of the stall.
         hold_data_reg  <= data_sram_rdata;
         hold_valid_reg <= 1'b1;
      end
   end

   assign rdata_eff = hold_valid_reg ? hold_data_reg : data_sram_rdata;

   load_align u_load_align (
      .code (stage_reg.data_ram_readen),
      .addr (stage_reg.ex_result[1:0]),
      .word (rdata_eff),
      .data (load_data)
   );

   assign rf_wdata = (stage_reg.sel_rf_res && stage_reg.data_ram_en) ? load_data
                                                                     : stage_reg.ex_result;

   assign mem_to_wb_bus = {stage_reg.hi_we, stage_reg.lo_we, stage_reg.hi_ex, stage_reg.lo_ex,
                           stage_reg.ex_pc, stage_reg.rf_we, stage_reg.rf_waddr, rf_wdata};

   // rf_waddr==0 is forwarded unfiltered; the decode stage ignores it.
   assign mem_to_id_bus = {stage_reg.rf_we, stage_reg.rf_waddr, rf_wdata,
                           stage_reg.hi_we, stage_reg.lo_we, stage_reg.hi_ex, stage_reg.lo_ex};
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected bus images are queued when a step is
// driven and popped/compared once the stage presents that step's result.
module tb_mem_stage;
   logic         clk;
   logic         rst;
   logic [5:0]   stall;
   logic [145:0] ex_to_mem_bus;
   logic [31:0]  data_sram_rdata;
   logic [135:0] mem_to_wb_bus;
   logic [103:0] mem_to_id_bus;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]  rd;
      logic        hi_we;
      logic        lo_we;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] pc;
      logic        ram_en;
      logic [3:0]  wen;
      logic        sel;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] res;
   } instr_t;

   typedef struct {
      string        tag;
      logic [135:0] wb;
      logic [103:0] id;
   } exp_t;

   exp_t sb[$];

   localparam logic [5:0] RUN    = 6'b000000;
   localparam logic [5:0] HOLD   = 6'b011000;
   localparam logic [5:0] BUBBLE = 6'b001000;

   mem_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .data_sram_rdata (data_sram_rdata),
      .mem_to_wb_bus   (mem_to_wb_bus),
      .mem_to_id_bus   (mem_to_id_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic instr_t zero_i();
      instr_t i;
      i = '{rd: 4'd0, hi_we: 1'b0, lo_we: 1'b0, hi: 32'd0, lo: 32'd0, pc: 32'd0, ram_en: 1'b0,
            wen: 4'd0, sel: 1'b0, we: 1'b0, waddr: 5'd0, res: 32'd0};
      return i;
   endfunction

   function automatic instr_t mk_load(input logic [3:0] code, input logic [31:0] addr,
                                      input logic [4:0] waddr, input logic [31:0] pc);
      instr_t i;
      i = zero_i();
      i.rd = code; i.ram_en = 1'b1; i.sel = 1'b1; i.we = 1'b1;
      i.waddr = waddr; i.res = addr; i.pc = pc;
      return i;
   endfunction

   function automatic instr_t mk_alu(input logic [31:0] res, input logic [4:0] waddr,
                                     input logic [31:0] pc);
      instr_t i;
      i = zero_i();
      i.we = 1'b1; i.waddr = waddr; i.res = res; i.pc = pc;
      return i;
   endfunction

   function automatic logic [145:0] pack_ex(input instr_t i);
      return {i.rd, i.hi_we, i.lo_we, i.hi, i.lo, i.pc, i.ram_en, i.wen, i.sel, i.we,
              i.waddr, i.res};
   endfunction

   // Reference load semantics: shift the addressed lane down, then extend.
   function automatic logic [31:0] ref_wdata(input instr_t i, input logic [31:0] r);
      logic [31:0] sh;
      logic [31:0] v;
      if (!(i.sel && i.ram_en)) return i.res;
      v = 32'd0;
      case (i.rd)
         4'b1111: v = r;
         4'b0001: begin sh = r >> (8 * i.res[1:0]); v = {{24{sh[7]}}, sh[7:0]}; end
         4'b0010: begin sh = r >> (8 * i.res[1:0]); v = {24'd0, sh[7:0]}; end
         4'b0011: begin sh = r >> (16 * i.res[1]); v = {{16{sh[15]}}, sh[15:0]}; end
         4'b0100: begin sh = r >> (16 * i.res[1]); v = {16'd0, sh[15:0]}; end
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   task automatic check_one();
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (mem_to_wb_bus === e.wb) else begin
         errors++;
         $error("FAIL %s wb observed=%h expected=%h", e.tag, mem_to_wb_bus, e.wb);
      end
      checks++;
      assert (mem_to_id_bus === e.id) else begin
         errors++;
         $error("FAIL %s id observed=%h expected=%h", e.tag, mem_to_id_bus, e.id);
      end
   endtask

   // drv: bus presented to the stage; res_i/eff: instruction and read word expected
   // at the outputs after the edge; rdata: SRAM word driven during that cycle.
   task automatic step(input string tag, input instr_t drv, input logic [5:0] st,
                       input logic r, input logic [31:0] rdata,
                       input instr_t res_i, input logic [31:0] eff);
      exp_t e;
      logic [31:0] wd;
      @(negedge clk);
      rst = r;
      stall = st;
      ex_to_mem_bus = pack_ex(drv);
      wd = ref_wdata(res_i, eff);
      e.tag = tag;
      e.wb = {res_i.hi_we, res_i.lo_we, res_i.hi, res_i.lo, res_i.pc, res_i.we, res_i.waddr, wd};
      e.id = {res_i.we, res_i.waddr, wd, res_i.hi_we, res_i.lo_we, res_i.hi, res_i.lo};
      sb.push_back(e);
      @(posedge clk);
      #1 data_sram_rdata = rdata;
      #1 check_one();
   endtask

   initial begin
      instr_t z, lb_i, lbu_i, lh_i, lhu_i, lw_i, lb0_i, lb2_i, sb_i, alu_i, mult_i, junk_i, lw0_i;
      z      = zero_i();
      lb_i   = mk_load(4'b0001, 32'h1000_0003, 5'd2, 32'hBFC0_0000);
      lbu_i  = mk_load(4'b0010, 32'h1000_0003, 5'd3, 32'hBFC0_0004);
      lh_i   = mk_load(4'b0011, 32'h1000_0002, 5'd4, 32'hBFC0_0008);
      lhu_i  = mk_load(4'b0100, 32'h1000_0000, 5'd5, 32'hBFC0_000C);
      lb0_i  = mk_load(4'b0001, 32'h1000_0000, 5'd6, 32'hBFC0_0010);
      lb2_i  = mk_load(4'b0010, 32'h1000_0002, 5'd7, 32'hBFC0_0014);
      lw_i   = mk_load(4'b1111, 32'h1000_0010, 5'd9, 32'hBFC0_0018);
      sb_i   = mk_load(4'b0101, 32'h1000_0021, 5'd0, 32'hBFC0_001C);
      sb_i.sel = 1'b0; sb_i.we = 1'b0; sb_i.wen = 4'b0010;
      alu_i  = mk_alu(32'h0000_0055, 5'd8, 32'hBFC0_0020);
      mult_i = zero_i();
      mult_i.hi_we = 1'b1; mult_i.lo_we = 1'b1; mult_i.hi = 32'h1; mult_i.lo = 32'h2;
      mult_i.pc = 32'hBFC0_0024;
      junk_i = mk_alu(32'hA5A5_A5A5, 5'd31, 32'hBFC0_0FFC);
      lw0_i  = mk_load(4'b1111, 32'h1000_0040, 5'd0, 32'hBFC0_0028);

      rst = 1'b1; stall = RUN; ex_to_mem_bus = '0; data_sram_rdata = '0;

      step("reset0", junk_i, RUN, 1'b1, 32'h0, z, 32'h0);
      step("reset1", junk_i, HOLD, 1'b1, 32'h0, z, 32'h0);
      step("lb_b3",  lb_i,  RUN, 1'b0, 32'h80FF_1234, lb_i,  32'h80FF_1234);
      step("lbu_b3", lbu_i, RUN, 1'b0, 32'h80FF_1234, lbu_i, 32'h80FF_1234);
      step("lh_h1",  lh_i,  RUN, 1'b0, 32'h8001_7FFF, lh_i,  32'h8001_7FFF);
      step("lhu_h0", lhu_i, RUN, 1'b0, 32'h8001_7FFF, lhu_i, 32'h8001_7FFF);
      step("lb_b0",  lb0_i, RUN, 1'b0, 32'h1234_56F0, lb0_i, 32'h1234_56F0);
      step("lbu_b2", lb2_i, RUN, 1'b0, 32'h12C4_5678, lb2_i, 32'h12C4_5678);
      step("sb_nonload", sb_i, RUN, 1'b0, 32'hFFFF_FFFF, sb_i, 32'hFFFF_FFFF);
      step("lw",     lw_i,  RUN, 1'b0, 32'h1234_5678, lw_i, 32'h1234_5678);
      step("lw_hold1", junk_i, HOLD, 1'b0, 32'hDEAD_BEEF, lw_i, 32'h1234_5678);
      step("lw_hold2", junk_i, HOLD, 1'b0, 32'hDEAD_BEEF, lw_i, 32'h1234_5678);
      step("lw_hold3", junk_i, HOLD, 1'b0, 32'hDEAD_BEEF, lw_i, 32'h1234_5678);
      step("after_hold", lhu_i, RUN, 1'b0, 32'h0000_ABCD, lhu_i, 32'h0000_ABCD);
      step("bubble", alu_i, BUBBLE, 1'b0, 32'h0, z, 32'h0);
      step("alu_fwd", alu_i, RUN, 1'b0, 32'hFFFF_FFFF, alu_i, 32'hFFFF_FFFF);
      step("mult", mult_i, RUN, 1'b0, 32'h0, mult_i, 32'h0);
      step("mult_hold", junk_i, HOLD, 1'b0, 32'h0, mult_i, 32'h0);
      step("rst_mid_stall", junk_i, HOLD, 1'b1, 32'h0, z, 32'h0);
      step("post_rst_hold", junk_i, HOLD, 1'b0, 32'h0, z, 32'h0);
      step("waddr0", lw0_i, RUN, 1'b0, 32'hCAFE_F00D, lw0_i, 32'hCAFE_F00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
